// File: rtl/mem_access_pkg.sv
// Shared encodings and default sizing for the core-side memory access controller.
package mem_access_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/mem_access_cnt.sv
// Wrapping completion counters for successful fetch, load and store requests.
module mem_access_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_done_i,
  input  logic        load_done_i,
  input  logic        store_done_i,
  output logic [31:0] cnt_fetch_o,
  output logic [31:0] cnt_load_o,
  output logic [31:0] cnt_store_o
);

  logic [31:0] fetch_q, load_q, store_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      load_q  <= '0;
      store_q <= '0;
    end else begin
      if (fetch_done_i) fetch_q <= fetch_q + 32'd1;
      if (load_done_i)  load_q  <= load_q + 32'd1;
      if (store_done_i) store_q <= store_q + 32'd1;
    end
  end

  assign cnt_fetch_o = fetch_q;
  assign cnt_load_o  = load_q;
  assign cnt_store_o = store_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// One-outstanding-access controller between the core and the unified memory.
// Define ACCESS_CNT_EN to build the completion counters; otherwise they read 0.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [31:0]       mem_pc,
  output logic [31:0]       mem_rd_addr,
  output logic [31:0]       mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_inst,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       cnt_fetch,
  output logic [31:0]       cnt_load,
  output logic [31:0]       cnt_store
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              we_raw;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    we_raw     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = (req_op == OP_ILL) || (req_addr >= 32'(MEM_DEPTH));
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        we_raw    = (op_q == OP_STORE) && !err_q;
        rsp_err_d = err_q;
        if (err_q) begin
          rsp_data_d = '0;
        end else begin
          case (op_q)
            OP_FETCH: rsp_data_d = mem_inst;
            OP_LOAD:  rsp_data_d = mem_rdata;
            default:  rsp_data_d = '0;
          endcase
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // A reset landing on the access cycle must not let a store through.
  assign mem_we      = we_raw & ~rst;
  assign mem_pc      = addr_q;
  assign mem_rd_addr = addr_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = wdata_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

`ifdef ACCESS_CNT_EN
  logic rsp_done;
  assign rsp_done = rsp_valid & rsp_ready & ~rsp_err_q;

  mem_access_cnt u_cnt (
    .clk          (clk),
    .rst          (rst),
    .fetch_done_i (rsp_done && (op_q == OP_FETCH)),
    .load_done_i  (rsp_done && (op_q == OP_LOAD)),
    .store_done_i (rsp_done && (op_q == OP_STORE)),
    .cnt_fetch_o  (cnt_fetch),
    .cnt_load_o   (cnt_load),
    .cnt_store_o  (cnt_store)
  );
`else
  assign cnt_fetch = '0;
  assign cnt_load  = '0;
  assign cnt_store = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed requests against a small memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_pc, mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic        mem_we;
  logic [31:0] mem_inst, mem_rdata;
  logic [31:0] cnt_fetch, cnt_load, cnt_store;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rsp_seen = 0;
  int   rsp_issued = 0;

  mem_access_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .mem_pc      (mem_pc),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_we      (mem_we),
    .mem_inst    (mem_inst),
    .mem_rdata   (mem_rdata),
    .cnt_fetch   (cnt_fetch),
    .cnt_load    (cnt_load),
    .cnt_store   (cnt_store)
  );

  always #5 clk = ~clk;

  assign mem_inst  = (mem_pc < 32'd256) ? mem[mem_pc[7:0]] : 32'h0;
  assign mem_rdata = (mem_rd_addr < 32'd256) ? mem[mem_rd_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_wr_addr < 32'd256) mem[mem_wr_addr[7:0]] <= mem_wr_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        checkOutput("unexpected_rsp", rsp_data, 32'hXXXX_XXXX);
      end else begin
        e = rsp_q.pop_front();
        checkOutput("rsp_data", rsp_data, e.data);
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
      rsp_seen++;
    end
  end

  // Write monitor: each cycle of mem_we consumes exactly one expected write.
  always @(negedge clk) begin
    wr_t w;
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_we", mem_wr_addr, 32'hXXXX_XXXX);
      end else begin
        w = wr_q.pop_front();
        checkOutput("we_addr", mem_wr_addr, w.addr);
        checkOutput("we_data", mem_wr_data, w.data);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr, input bit bp);
    int  seen0;
    bit  ok;
    rsp_t r;
    wr_t  w;
    r.data = expData;
    r.err  = expErr;
    rsp_q.push_back(r);
    rsp_issued++;
    if (op == 2'b10 && !expErr) begin
      w.addr = addr;
      w.data = wdata;
      wr_q.push_back(w);
    end
    seen0 = rsp_seen;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    if (bp) rsp_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("access_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("access_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("mem_pc", mem_pc, addr);
    checkOutput("mem_rd_addr", mem_rd_addr, addr);
    checkOutput("mem_wr_addr", mem_wr_addr, addr);
    checkOutput("mem_wr_data", mem_wr_data, wdata);
    @(negedge clk);
    checkOutput("latency_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    if (bp) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 32'd0;
        @(negedge clk);
        checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        checkOutput("bp_rsp_data", rsp_data, expData);
        checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    ok = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (rsp_seen != seen0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("reset_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("reset_mem_pc", mem_pc, 32'd0);
    checkOutput("reset_mem_rd_addr", mem_rd_addr, 32'd0);
    checkOutput("reset_mem_wr_addr", mem_wr_addr, 32'd0);
    checkOutput("reset_mem_wr_data", mem_wr_data, 32'd0);
    checkOutput("reset_cnt_fetch", cnt_fetch, 32'd0);
    checkOutput("reset_cnt_load", cnt_load, 32'd0);
    checkOutput("reset_cnt_store", cnt_store, 32'd0);

    // Store aborted by reset during its access cycle.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = 32'd9;
    req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("rst_test_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checkOutput("rst_access_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_after_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_after_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_after_rsp_data", rsp_data, 32'd0);

    applyStimulus(2'b01, 32'd9,          32'd0,         32'h1000_0009, 1'b0, 1'b0);
    applyStimulus(2'b10, 32'd5,          32'hDEAD_BEEF, 32'd0,         1'b0, 1'b0);
    applyStimulus(2'b01, 32'd5,          32'd0,         32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(2'b00, 32'd5,          32'd0,         32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(2'b01, 32'd7,          32'd0,         32'h1000_0007, 1'b0, 1'b1);
    applyStimulus(2'b10, 32'd256,        32'h1234_5678, 32'd0,         1'b1, 1'b0);
    applyStimulus(2'b11, 32'd0,          32'hAAAA_5555, 32'd0,         1'b1, 1'b0);
    applyStimulus(2'b01, 32'h8000_0005,  32'd0,         32'd0,         1'b1, 1'b0);
    applyStimulus(2'b01, 32'd255,        32'd0,         32'h1000_00FF, 1'b0, 1'b0);
    applyStimulus(2'b00, 32'd0,          32'd0,         32'h1000_0000, 1'b0, 1'b0);

    @(negedge clk);
`ifdef ACCESS_CNT_EN
    checkOutput("cnt_fetch", cnt_fetch, 32'd2);
    checkOutput("cnt_load", cnt_load, 32'd4);
    checkOutput("cnt_store", cnt_store, 32'd1);
`else
    checkOutput("cnt_fetch", cnt_fetch, 32'd0);
    checkOutput("cnt_load", cnt_load, 32'd0);
    checkOutput("cnt_store", cnt_store, 32'd0);
`endif
    checkOutput("rsp_queue_left", 32'(rsp_q.size()), 32'd0);
    checkOutput("wr_queue_left", 32'(wr_q.size()), 32'd0);
    checkOutput("rsp_count", 32'(rsp_seen), 32'(rsp_issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
